// File: rtl/multi_push_fifo_if.sv
// Handshake bundle for multi_push_fifo: multi-lane push side, scalar pop side,
// plus the level/status outputs. The FIFO takes the slave modport.
interface multi_push_fifo_if #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 6,
    parameter int PUSH_MAX   = 4
) ();
    localparam int CW = $clog2(PUSH_MAX + 1);

    logic                      push_valid;
    logic [CW-1:0]             push_count;
    logic [PUSH_MAX*WIDTH-1:0] push_data;
    logic                      push_ready;
    logic                      pop_valid;
    logic                      pop_ready;
    logic [WIDTH-1:0]          pop_data;
    logic [DEPTH_LOG2:0]       level;
    logic                      almost_full;
    logic                      almost_empty;
    logic                      overflow;

    modport master (
        output push_valid, push_count, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, level,
               almost_full, almost_empty, overflow
    );

    modport slave (
        input  push_valid, push_count, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, level,
               almost_full, almost_empty, overflow
    );
endinterface

// File: rtl/multi_push_fifo.sv
// multi_push_fifo: accepts 0..PUSH_MAX entries per cycle, delivers one per cycle
// through a registered output stage. Storage is 2**DEPTH_LOG2 entries.
// Optional build macro MULTI_PUSH_FIFO_BYPASS_EN: when storage is empty and the
// output stage can load, push lane 0 goes straight to pop_data (1-cycle latency).
module multi_push_fifo #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 6,
    parameter int PUSH_MAX   = 4,
    parameter int AFULL_FREE = 8,
    parameter int AEMPTY_LVL = 1
) (
    input logic               clk,
    input logic               reset,
    multi_push_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic                  r_pop_valid;
    logic [WIDTH-1:0]      r_pop_data;
    logic                  r_overflow;

    logic [PW-1:0]         w_count;
    logic [PW-1:0]         w_free;
    logic                  w_push_ready;
    logic                  w_push_req;
    logic                  w_push_fire;
    logic                  w_load_ok;
    logic                  w_out_load;
    logic                  w_skip;
    logic [PW-1:0]         w_n_store;
    logic [DEPTH_LOG2-1:0] w_wr_addr [PUSH_MAX];
    logic [PUSH_MAX-1:0]   w_wr_en;

    assign w_count      = r_head - r_tail;
    assign w_free       = PW'(DEPTH) - w_count;
    assign w_push_ready = (w_free >= PW'(PUSH_MAX));
    assign w_push_req   = bus.push_valid && (bus.push_count != '0);
    assign w_push_fire  = w_push_req && w_push_ready;
    assign w_load_ok    = !r_pop_valid || bus.pop_ready;
    assign w_out_load   = w_load_ok && (w_count != '0);

`ifdef MULTI_PUSH_FIFO_BYPASS_EN
    // Lane 0 bypasses storage only when nothing older is stored.
    assign w_skip = w_push_fire && w_load_ok && (w_count == '0);
`else
    assign w_skip = 1'b0;
`endif

    // Bypassed lane 0 is not stored, so remaining lanes shift down by one slot.
    assign w_n_store = PW'(bus.push_count) - PW'(w_skip);

    // Per-lane storage address and write enable; addresses wrap mod DEPTH.
    always_comb begin
        for (int unsigned i = 0; i < PUSH_MAX; i++) begin
            w_wr_addr[i] = r_head[DEPTH_LOG2-1:0] + DEPTH_LOG2'(i) - DEPTH_LOG2'(w_skip);
            w_wr_en[i]   = w_push_fire && (i < 32'(bus.push_count)) && !((i == 0) && w_skip);
        end
    end

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PUSH_MAX; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_addr[i]] <= bus.push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Head/tail pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_fire) begin
                r_head <= r_head + w_n_store;
            end
            if (w_out_load) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_push_req && !w_push_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output register: load from storage head, or from push lane 0 on bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else if (w_out_load) begin
            r_pop_valid <= 1'b1;
            r_pop_data  <= r_mem[r_tail[DEPTH_LOG2-1:0]];
        end else if (w_skip) begin
            r_pop_valid <= 1'b1;
            r_pop_data  <= bus.push_data[WIDTH-1:0];
        end else if (bus.pop_ready) begin
            r_pop_valid <= 1'b0;
        end
    end

    assign bus.push_ready   = w_push_ready;
    assign bus.pop_valid    = r_pop_valid;
    assign bus.pop_data     = r_pop_data;
    assign bus.level        = w_count + PW'(r_pop_valid);
    assign bus.almost_full  = (w_free < PW'(AFULL_FREE));
    assign bus.almost_empty = (bus.level <= PW'(AEMPTY_LVL));
    assign bus.overflow     = r_overflow;
endmodule

// File: tb/tb_multi_push_fifo.sv
// Self-checking bench for multi_push_fifo with a queue scoreboard and a
// cycle-level occupancy model.
module tb_multi_push_fifo;
    localparam int WIDTH      = 18;
    localparam int DEPTH_LOG2 = 6;
    localparam int PUSH_MAX   = 4;
    localparam int AFULL_FREE = 8;
    localparam int AEMPTY_LVL = 1;
    localparam int DEPTH      = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_push_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .PUSH_MAX(PUSH_MAX)) bus ();

    multi_push_fifo #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .PUSH_MAX(PUSH_MAX),
        .AFULL_FREE(AFULL_FREE), .AEMPTY_LVL(AEMPTY_LVL)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q [$];
    bit               m_pv;
    bit               m_ovf;
    logic [WIDTH-1:0] next_tag;
    logic [WIDTH-1:0] last_data;
    bit               last_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_store();
        return exp_q.size() - int'(m_pv);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_pv = 0;
        m_ovf = 0;
        last_stall = 0;
    endtask

    task automatic check_state(input string tag);
        int st;
        int free;
        st = m_store();
        free = DEPTH - st;
        check({tag, ".level"},  32'(bus.level), exp_q.size());
        check({tag, ".pvalid"}, 32'(bus.pop_valid), 32'(m_pv));
        check({tag, ".pready"}, 32'(bus.push_ready), 32'(free >= PUSH_MAX));
        check({tag, ".afull"},  32'(bus.almost_full), 32'(free < AFULL_FREE));
        check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(exp_q.size() <= AEMPTY_LVL));
        check({tag, ".ovf"},    32'(bus.overflow), 32'(m_ovf));
        if (m_pv) check({tag, ".pop_data"}, 32'(bus.pop_data), 32'(exp_q[0]));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".pvalid"}, 32'(bus.pop_valid), 0);
        check({tag, ".pdata"},  32'(bus.pop_data), 0);
        check({tag, ".level"},  32'(bus.level), 0);
        check({tag, ".pready"}, 32'(bus.push_ready), 1);
        check({tag, ".aempty"}, 32'(bus.almost_empty), 1);
        check({tag, ".afull"},  32'(bus.almost_full), 0);
        check({tag, ".ovf"},    32'(bus.overflow), 0);
    endtask

    // Drive one cycle at the falling edge, check pre-edge outputs, advance model.
    task automatic step(input bit pv, input int cnt, input bit pr);
        logic [PUSH_MAX*WIDTH-1:0] d;
        int st;
        bit ready, fire, load_ok, load, byp;
        for (int i = 0; i < PUSH_MAX; i++) d[i*WIDTH +: WIDTH] = next_tag + WIDTH'(i);
        bus.push_valid = pv;
        bus.push_count = 3'(cnt);
        bus.push_data  = d;
        bus.pop_ready  = pr;
        #1;
        check_state("cyc");
        if (last_stall && m_pv) check("stall.stable", 32'(bus.pop_data), 32'(last_data));
        last_stall = m_pv && !pr;
        last_data  = bus.pop_data;
        st      = m_store();
        ready   = (DEPTH - st) >= PUSH_MAX;
        fire    = pv && (cnt != 0) && ready;
        load_ok = !m_pv || pr;
        load    = load_ok && (st != 0);
        byp     = 0;
`ifdef MULTI_PUSH_FIFO_BYPASS_EN
        byp     = load_ok && (st == 0) && fire;
`endif
        if (pv && (cnt != 0) && !ready) m_ovf = 1;
        if (m_pv && pr) void'(exp_q.pop_front());
        if (fire) begin
            for (int i = 0; i < cnt; i++) exp_q.push_back(next_tag + WIDTH'(i));
            next_tag = next_tag + WIDTH'(cnt);
        end
        m_pv = load || byp || (m_pv && !pr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_count = '0;
        bus.pop_ready  = 1'b0;
        @(negedge clk);
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step(0, 0, 1);
        check({tag, ".drained"}, exp_q.size(), 0);
        step(0, 0, 1);
        check({tag, ".final_level"}, 32'(bus.level), 0);
    endtask

    initial begin
        logic [4:0] seen;
        logic [4:0] want;
        bus.push_data = '0;
        next_tag = '0;
        model_clear();

        // 1: reset values, then a 3-lane push and its latency profile.
        do_reset("rst");
        next_tag = 18'h0A;
        step(1, 3, 1);
        for (int k = 0; k < 5; k++) begin
            seen[k] = bus.pop_valid;
            step(0, 0, 1);
        end
`ifdef MULTI_PUSH_FIFO_BYPASS_EN
        want = 5'b00111;
`else
        want = 5'b01110;
`endif
        check("t1.latency", 32'(seen), 32'(want));
        check("t1.level", 32'(bus.level), 0);

        // 2: fill with pop stalled, then an overflowing push.
        do_reset("t2rst");
        for (int k = 0; k < 16; k++) step(1, 4, 0);
        check("t2.level_full", 32'(bus.level), 64);
        check("t2.pready_low", 32'(bus.push_ready), 0);
        check("t2.afull", 32'(bus.almost_full), 1);
        step(1, 4, 0);
        check("t2.ovf_set", 32'(bus.overflow), 1);
        check("t2.level_same", 32'(bus.level), 64);

        // 3: wrap; pointers offset so bundles straddle the end of storage.
        do_reset("t3rst");
        for (int k = 0; k < 15; k++) step(1, 4, 0);
        step(1, 2, 0);
        for (int k = 0; k < 58; k++) step(0, 0, 1);
        next_tag = '0;
        for (int k = 0; k < 4; k++) step(1, 4, 0);
        drain("t3");

        // 4: push 2 / pop 1 per cycle, then keep going into almost_full.
        do_reset("t4rst");
        for (int k = 0; k < 20; k++) step(1, 2, 1);
`ifdef MULTI_PUSH_FIFO_BYPASS_EN
        check("t4.level20", 32'(bus.level), 21);
`else
        check("t4.level20", 32'(bus.level), 22);
`endif
        for (int k = 0; k < 60 && (DEPTH - m_store()) >= AFULL_FREE; k++) step(1, 2, 1);
        check("t4.afull", 32'(bus.almost_full), 1);
        drain("t4");

        // 5: random push counts and random consumer stalls.
        do_reset("t5rst");
        for (int k = 0; k < 1000; k++)
            step(($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 1));
        drain("t5");

        // 6: asynchronous reset mid-burst, then a clean single push.
        do_reset("t6rst");
        for (int k = 0; k < 7; k++) step(1, 4, 0);
        step(1, 2, 0);
        check("t6.level30", 32'(bus.level), 30);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("t6.async");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        next_tag = 18'h2AAAA;
        step(1, 1, 1);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
